pipe_ctrl: RTL and testbench

- Parametrised pipeline control unit for the in-order RISC-V core.
- Replaces hard-wired "stall everything on ibus wait" with per-stage stall, flush and bubble generation.
- Tracks a valid bit per stage; handles ibus/dbus wait, load-use interlock and branch redirect (including a redirect that arrives while an ibus request is outstanding).
- Emits a single-shot commit strobe and performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 20 ++
 rtl/pipe_hazard.sv | 54 +++++
 rtl/pipe_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: stage indices,
// the redirect FSM state type and a stage-vector type at the default depth.
package pipe_ctrl_pkg;

    localparam int ST_F = 0;
    localparam int ST_D = 1;
    localparam int ST_E = 2;
    localparam int ST_M = 3;
    localparam int ST_W = 4;

    localparam int DEF_NSTAGES = 5;

    typedef enum logic {
        RUN  = 1'b0,
        DROP = 1'b1
    } fsm_t;

    typedef logic [DEF_NSTAGES-1:0] stage_vec_t;

endpackage

// File: rtl/pipe_hazard.sv
// Combinational hazard detection: derives the dbus, load-use and ibus stall
// causes, decides whether a redirect is taken, and builds the per-stage
// stall and flush vectors from them.
module pipe_hazard
    import pipe_ctrl_pkg::*;
#(
    parameter int NSTAGES   = 5,
    parameter int EX_STAGE  = ST_E,
    parameter int MEM_STAGE = ST_M,
    parameter int RA_W      = 5
) (
    input  fsm_t               state,
    input  logic               ex_valid,
    input  logic               mem_valid,
    input  logic               if_req_valid,
    input  logic               if_data_ok,
    input  logic               mem_req_valid,
    input  logic               mem_data_ok,
    input  logic               ex_is_load,
    input  logic [RA_W-1:0]    ex_dst,
    input  logic [RA_W-1:0]    id_rs1,
    input  logic [RA_W-1:0]    id_rs2,
    input  logic               id_use1,
    input  logic               id_use2,
    input  logic               redirect_valid,
    output logic               if_stall,
    output logic               redir_taken,
    output logic [NSTAGES-1:0] stall,
    output logic [NSTAGES-1:0] flush
);

    logic mem_stall;
    logic lu_hit;
    logic lu_stall;

    // Stall causes and stall/flush masks; the dbus wait freezes everything up
    // to MEM and swallows redirects, a taken redirect cancels the load-use hold.
    always_comb begin
        mem_stall   = mem_req_valid & mem_valid & ~mem_data_ok;
        if_stall    = if_req_valid & ~if_data_ok;
        redir_taken = (state == RUN) & redirect_valid & ~mem_stall;
        lu_hit      = (id_use1 & (id_rs1 == ex_dst)) | (id_use2 & (id_rs2 == ex_dst));
        lu_stall    = ex_is_load & ex_valid & (ex_dst != '0) & lu_hit & ~redir_taken;
        stall       = '0;
        flush       = '0;
        for (int k = 0; k < NSTAGES; k++) begin
            stall[k] = (mem_stall && (k <= MEM_STAGE))
                    || (lu_stall && (k < EX_STAGE))
                    || (if_stall && (k == 0));
            flush[k] = redir_taken && (k < EX_STAGE);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: per-stage valid tracking, the RUN/DROP redirect FSM
// that defers a redirect past an outstanding ibus request, commit strobe and
// performance counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NSTAGES   = 5,
    parameter int EX_STAGE  = ST_E,
    parameter int MEM_STAGE = ST_M,
    parameter int XLEN      = 64,
    parameter int RA_W      = 5,
    parameter int CNT_W     = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               if_req_valid,
    input  logic               if_data_ok,
    input  logic               mem_req_valid,
    input  logic               mem_data_ok,
    input  logic               ex_is_load,
    input  logic [RA_W-1:0]    ex_dst,
    input  logic [RA_W-1:0]    id_rs1,
    input  logic [RA_W-1:0]    id_rs2,
    input  logic               id_use1,
    input  logic               id_use2,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_target,
    output logic [NSTAGES-1:0] stall,
    output logic [NSTAGES-1:0] flush,
    output logic [NSTAGES-1:0] stage_valid,
    output logic               pc_stall,
    output logic               pc_redirect,
    output logic [XLEN-1:0]    redirect_pc,
    output logic               fetch_drop,
    output logic               commit_valid,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic [CNT_W-1:0]   instr_cnt,
    output logic [CNT_W-1:0]   stall_cnt
);

    fsm_t              state;
    fsm_t              state_next;
    logic [XLEN-1:0]   target_q;
    logic [NSTAGES-1:0] valid_q;
    logic              if_stall;
    logic              redir_taken;
    logic              fetch_produced;

    pipe_hazard #(
        .NSTAGES   (NSTAGES),
        .EX_STAGE  (EX_STAGE),
        .MEM_STAGE (MEM_STAGE),
        .RA_W      (RA_W)
    ) u_hazard (
        .state          (state),
        .ex_valid       (valid_q[EX_STAGE]),
        .mem_valid      (valid_q[MEM_STAGE]),
        .if_req_valid   (if_req_valid),
        .if_data_ok     (if_data_ok),
        .mem_req_valid  (mem_req_valid),
        .mem_data_ok    (mem_data_ok),
        .ex_is_load     (ex_is_load),
        .ex_dst         (ex_dst),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_use1        (id_use1),
        .id_use2        (id_use2),
        .redirect_valid (redirect_valid),
        .if_stall       (if_stall),
        .redir_taken    (redir_taken),
        .stall          (stall),
        .flush          (flush)
    );

    assign stage_valid    = valid_q;
    assign commit_valid   = valid_q[NSTAGES-1] & ~stall[NSTAGES-1];
    assign fetch_produced = if_data_ok & ~fetch_drop & ~redir_taken;

    // Redirect FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_next;
    end

    // Enter DROP when a redirect meets an outstanding ibus request; leave once
    // that stale response has arrived and been discarded.
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (redir_taken && if_stall) state_next = DROP;
            DROP:    if (if_data_ok) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // PC control: immediate redirect in RUN, deferred redirect from the
    // latched target when the stale ibus response lands in DROP.
    always_comb begin
        pc_redirect = 1'b0;
        redirect_pc = redirect_target;
        fetch_drop  = 1'b0;
        pc_stall    = stall[ST_F];
        case (state)
            RUN: pc_redirect = redir_taken & ~if_stall;
            DROP: begin
                pc_redirect = if_data_ok;
                fetch_drop  = if_data_ok;
                redirect_pc = target_q;
                pc_stall    = ~if_data_ok;
            end
            default: ;
        endcase
    end

    // Hold the redirect target while waiting out the stale ibus response.
    always_ff @(posedge clk) begin
        if (reset)                                          target_q <= '0;
        else if ((state == RUN) && redir_taken && if_stall) target_q <= redirect_target;
    end

    // Per-stage valid bits: hold on stall, bubble behind a stalled or flushed
    // stage, otherwise advance; a flushed F slot never holds its instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            if (flush[0])       valid_q[0] <= 1'b0;
            else if (!stall[0]) valid_q[0] <= fetch_produced;
            for (int k = 1; k < NSTAGES; k++) begin
                if (!stall[k]) valid_q[k] <= (flush[k-1] | stall[k-1]) ? 1'b0 : valid_q[k-1];
            end
        end
    end

    // Free-running performance counters, wrapping naturally at full width.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            instr_cnt <= instr_cnt + CNT_W'(commit_valid);
            stall_cnt <= stall_cnt + CNT_W'(stall[ST_F]);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized self-checking bench for pipe_ctrl against an instruction-tag
// reference model of the pipeline.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req_valid, if_data_ok, mem_req_valid, mem_data_ok;
    logic        ex_is_load, id_use1, id_use2, redirect_valid;
    logic [4:0]  ex_dst, id_rs1, id_rs2;
    logic [63:0] redirect_target;
    logic [4:0]  stall, flush, stage_valid;
    logic        pc_stall, pc_redirect, fetch_drop, commit_valid;
    logic [63:0] redirect_pc, cycle_cnt, instr_cnt, stall_cnt;

    int total = 0;
    int bad   = 0;

    // model state: instruction tag per stage (0 = bubble)
    int          ids[5];
    int          next_id = 1;
    bit          m_drop;
    logic [63:0] m_tgt, m_cyc, m_ins, m_stc;

    // model expectations for the current cycle
    stage_vec_t  e_stall, e_flush;
    bit          e_take, e_ifs, e_mems, e_lus, e_pcredir, e_fdrop, e_pcstall, e_commit;
    logic [63:0] e_rpc;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_data_ok(if_data_ok),
        .mem_req_valid(mem_req_valid), .mem_data_ok(mem_data_ok),
        .ex_is_load(ex_is_load), .ex_dst(ex_dst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .stall(stall), .flush(flush), .stage_valid(stage_valid),
        .pc_stall(pc_stall), .pc_redirect(pc_redirect), .redirect_pc(redirect_pc),
        .fetch_drop(fetch_drop), .commit_valid(commit_valid),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .stall_cnt(stall_cnt)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic stage_vec_t valid_vec();
        stage_vec_t v = '0;
        for (int k = 0; k < 5; k++) v[k] = (ids[k] != 0);
        return v;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 5; k++) ids[k] = 0;
        m_drop = 0; m_tgt = '0; m_cyc = '0; m_ins = '0; m_stc = '0;
    endtask

    // expected combinational behaviour from the stall-cause rules
    task automatic modelComb();
        bit hit;
        e_mems  = mem_req_valid && (ids[3] != 0) && !mem_data_ok;
        e_ifs   = if_req_valid && !if_data_ok;
        e_take  = !m_drop && redirect_valid && !e_mems;
        hit     = (id_use1 && id_rs1 == ex_dst) || (id_use2 && id_rs2 == ex_dst);
        e_lus   = ex_is_load && (ids[2] != 0) && ex_dst != 0 && hit && !e_take;
        e_stall = (e_mems ? 5'b01111 : 5'b0) | (e_lus ? 5'b00011 : 5'b0) | (e_ifs ? 5'b00001 : 5'b0);
        e_flush = e_take ? 5'b00011 : 5'b0;
        e_pcredir = m_drop ? if_data_ok : (e_take && !e_ifs);
        e_fdrop   = m_drop && if_data_ok;
        e_rpc     = m_drop ? m_tgt : redirect_target;
        e_pcstall = m_drop ? !if_data_ok : e_stall[0];
        e_commit  = ids[4] != 0;
    endtask

    // advance the tagged pipeline by one clock
    task automatic modelStep();
        bit produced;
        produced = if_data_ok && !e_fdrop && !e_take;
        for (int k = 4; k >= 1; k--)
            if (!e_stall[k]) ids[k] = (e_flush[k-1] || e_stall[k-1]) ? 0 : ids[k-1];
        if (e_flush[0]) ids[0] = 0;
        else if (!e_stall[0]) begin
            if (produced) begin ids[0] = next_id; next_id++; end
            else ids[0] = 0;
        end
        m_cyc = m_cyc + 1;
        m_ins = m_ins + 64'(e_commit);
        m_stc = m_stc + 64'(e_stall[0]);
        if (!m_drop && e_take && e_ifs) begin m_drop = 1; m_tgt = redirect_target; end
        else if (m_drop && if_data_ok) m_drop = 0;
    endtask

    task automatic applyStimulus(input int mode);
        if (mode == 0) begin
            if_req_valid = 1; if_data_ok = 1; mem_req_valid = 0; mem_data_ok = 0;
            ex_is_load = 0; id_use1 = 0; id_use2 = 0; redirect_valid = 0;
            ex_dst = 0; id_rs1 = 0; id_rs2 = 0; redirect_target = '0;
        end else begin
            if_req_valid    = ($urandom_range(0, 7) != 0);
            if_data_ok      = ($urandom_range(0, 2) != 0);
            mem_req_valid   = ($urandom_range(0, 2) == 0);
            mem_data_ok     = ($urandom_range(0, 1) == 0);
            ex_is_load      = ($urandom_range(0, 1) == 0);
            ex_dst          = 5'($urandom_range(0, 3));
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            id_use1         = ($urandom_range(0, 1) == 0);
            id_use2         = ($urandom_range(0, 2) == 0);
            redirect_valid  = ($urandom_range(0, 5) == 0);
            redirect_target = {$urandom, $urandom};
        end
    endtask

    task automatic checkAll();
        modelComb();
        checkOutput("stall",        64'(stall),        64'(e_stall));
        checkOutput("flush",        64'(flush),        64'(e_flush));
        checkOutput("stage_valid",  64'(stage_valid),  64'(valid_vec()));
        checkOutput("pc_stall",     64'(pc_stall),     64'(e_pcstall));
        checkOutput("pc_redirect",  64'(pc_redirect),  64'(e_pcredir));
        checkOutput("fetch_drop",   64'(fetch_drop),   64'(e_fdrop));
        checkOutput("commit_valid", 64'(commit_valid), 64'(e_commit));
        if (e_pcredir) checkOutput("redirect_pc", redirect_pc, e_rpc);
        checkOutput("cycle_cnt", cycle_cnt, m_cyc);
        checkOutput("instr_cnt", instr_cnt, m_ins);
        checkOutput("stall_cnt", stall_cnt, m_stc);
    endtask

    task automatic doCycle(input int mode);
        @(negedge clk);
        applyStimulus(mode);
        #1;
        checkAll();
        @(posedge clk);
        modelStep();
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1;
        applyStimulus(1);
        @(posedge clk);
        modelReset();
        #1 reset = 0;
    endtask

    initial begin
        reset = 1;
        applyStimulus(0);
        if_req_valid = 0; if_data_ok = 0;
        @(posedge clk);
        doReset();
        @(negedge clk);
        applyStimulus(0);
        if_req_valid = 0; if_data_ok = 0;
        #1;
        checkOutput("rst_valid", 64'(stage_valid), 64'd0);
        checkOutput("rst_stall", 64'(stall), 64'd0);
        checkOutput("rst_flush", 64'(flush), 64'd0);
        checkOutput("rst_cycle", cycle_cnt, 64'd0);
        doReset();

        // cold fill with a fetch every cycle
        for (int i = 1; i <= 5; i++) begin
            doCycle(0);
            #1 checkOutput("fill_valid", 64'(stage_valid), (64'd1 << i) - 64'd1);
        end
        checkOutput("first_commit", 64'(commit_valid), 64'd1);
        doCycle(0);
        #1 checkOutput("first_instr_cnt", instr_cnt, 64'd1);

        for (int i = 0; i < 800; i++) doCycle(1);
        doReset();
        for (int i = 0; i < 10; i++) doCycle(0);
        for (int i = 0; i < 800; i++) doCycle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
